// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze and wait watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       br_taken,
    input  logic       imem_wait,
    input  logic       dmem_wait,
    output logic       pc_we,
    output logic       if_id_we,
    output logic       id_ex_we,
    output logic       ex_mem_we,
    output logic       mem_wb_we,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ld_haz,
    output logic       timeout,
    output logic [1:0] state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0] ld_stall_cnt,
    output logic [15:0] br_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_t     state_q;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       mem_wait;
    logic       lu_hit;
    logic       ld_stall_ev;
    logic       br_flush_ev;

    assign mem_wait = imem_wait | dmem_wait;
    assign lu_hit   = ex_memread && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (ex_rd == id_rs1)) ||
                       (id_rs2_used && (ex_rd == id_rs2)));

    always_comb begin
        state_next  = state_q;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ld_stall_ev = 1'b0;
        br_flush_ev = 1'b0;
        if (!rst_n) begin
            state_next = RUN;
        end else if (mem_wait) begin
            state_next = MEM_WAIT;
        end else if (br_taken) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_flush_ev = 1'b1;
            state_next  = RUN;
        // The stall cycle itself never re-arms a stall, so LOAD_STALL lasts one cycle.
        end else if (lu_hit && (state_q != LOAD_STALL)) begin
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            mem_wb_we   = 1'b1;
            id_ex_flush = 1'b1;
            ld_stall_ev = 1'b1;
            state_next  = LOAD_STALL;
        end else begin
            pc_we      = 1'b1;
            if_id_we   = 1'b1;
            id_ex_we   = 1'b1;
            ex_mem_we  = 1'b1;
            mem_wb_we  = 1'b1;
            state_next = RUN;
        end
    end

    always_comb begin
        wait_cnt_next = 8'd0;
        if (mem_wait) begin
            wait_cnt_next = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ld_haz   <= 1'b0;
            timeout  <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            state_q  <= state_next;
            ld_haz   <= (state_next == LOAD_STALL);
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

    assign state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_stall_cnt <= 16'd0;
            br_flush_cnt <= 16'd0;
        end else begin
            if (ld_stall_ev) begin
                ld_stall_cnt <= ld_stall_cnt + 16'd1;
            end
            if (br_flush_ev) begin
                br_flush_cnt <= br_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (built with WAIT_LIMIT = 4).
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_memread;
    logic       br_taken;
    logic       imem_wait;
    logic       dmem_wait;
    logic       pc_we;
    logic       if_id_we;
    logic       id_ex_we;
    logic       ex_mem_we;
    logic       mem_wb_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ld_haz;
    logic       timeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] ld_stall_cnt;
    logic [15:0] br_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush}
    logic [6:0] ctl;
    assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush};

    localparam logic [6:0] CTL_RUN  = 7'b1111100;
    localparam logic [6:0] CTL_LU   = 7'b0011101;
    localparam logic [6:0] CTL_BR   = 7'b1111111;
    localparam logic [6:0] CTL_HOLD = 7'b0000000;

    hazard_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .br_taken    (br_taken),
        .imem_wait   (imem_wait),
        .dmem_wait   (dmem_wait),
        .pc_we       (pc_we),
        .if_id_we    (if_id_we),
        .id_ex_we    (id_ex_we),
        .ex_mem_we   (ex_mem_we),
        .mem_wb_we   (mem_wb_we),
        .if_id_flush (if_id_flush),
        .id_ex_flush (id_ex_flush),
        .ld_haz      (ld_haz),
        .timeout     (timeout),
        .state       (state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .ld_stall_cnt(ld_stall_cnt),
        .br_flush_cnt(br_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs1      = 5'd3;
        id_rs2      = 5'd7;
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
        ex_rd       = 5'd0;
        ex_memread  = 1'b0;
        br_taken    = 1'b0;
        imem_wait   = 1'b0;
        dmem_wait   = 1'b0;
    endtask

    // Load in EX writing x5, decode reads x5 on RS2.
    task automatic load_use_inputs();
        idle_inputs();
        ex_memread  = 1'b1;
        ex_rd       = 5'd5;
        id_rs2      = 5'd5;
        id_rs2_used = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_use_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if ({ld_haz, timeout} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b want 00", {ld_haz, timeout}); end
        checks++;
        if (ctl !== CTL_HOLD) begin failures++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_HOLD); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin failures++; $display("FAIL reset_release_ctl: got %b want %b", ctl, CTL_RUN); end
        step();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_release_state: got %0d want 0", state); end
    endtask

    task automatic test_load_use();
        load_use_inputs();
        #1;
        checks++;
        if (ctl !== CTL_LU) begin failures++; $display("FAIL lu_c0_ctl: got %b want %b", ctl, CTL_LU); end
        step();
        ex_memread = 1'b0;
        ex_rd      = 5'd0;
        #1;
        checks++;
        if ({state, ld_haz} !== 3'b011) begin failures++; $display("FAIL lu_c1_state_ldhaz: got %b want 011", {state, ld_haz}); end
        checks++;
        if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_c1_ctl: got %b want %b", ctl, CTL_RUN); end
        step();
        checks++;
        if ({state, ld_haz} !== 3'b000) begin failures++; $display("FAIL lu_c2_state_ldhaz: got %b want 000", {state, ld_haz}); end
        // RS1 match also stalls
        idle_inputs();
        ex_memread = 1'b1;
        ex_rd      = 5'd3;
        #1;
        checks++;
        if (ctl !== CTL_LU) begin failures++; $display("FAIL lu_rs1_ctl: got %b want %b", ctl, CTL_LU); end
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_no_hazard();
        load_use_inputs();
        ex_rd  = 5'd0;
        id_rs2 = 5'd0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin failures++; $display("FAIL nohaz_x0_ctl: got %b want %b", ctl, CTL_RUN); end
        load_use_inputs();
        id_rs2_used = 1'b0;
        #1;
        checks++;
        if (ctl !== CTL_RUN) begin failures++; $display("FAIL nohaz_unused_ctl: got %b want %b", ctl, CTL_RUN); end
        step();
        checks++;
        if ({state, ld_haz} !== 3'b000) begin failures++; $display("FAIL nohaz_state: got %b want 000", {state, ld_haz}); end
        idle_inputs();
    endtask

    task automatic test_branch();
        load_use_inputs();
        br_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_BR) begin failures++; $display("FAIL br_ctl: got %b want %b", ctl, CTL_BR); end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({state, ld_haz} !== 3'b000) begin failures++; $display("FAIL br_state: got %b want 000", {state, ld_haz}); end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (br_flush_cnt !== 16'd1) begin failures++; $display("FAIL br_cnt: got %0d want 1", br_flush_cnt); end
`endif
    endtask

    task automatic test_mem_wait();
        load_use_inputs();
        dmem_wait = 1'b1;
        #1;
        checks++;
        if (ctl !== CTL_HOLD) begin failures++; $display("FAIL wait_c0_ctl: got %b want %b", ctl, CTL_HOLD); end
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if ({state, ctl} !== {2'd2, CTL_HOLD}) begin
                failures++;
                $display("FAIL wait_c%0d: got state=%0d ctl=%b want state=2 ctl=%b", k, state, ctl, CTL_HOLD);
            end
        end
        step();
        dmem_wait = 1'b0;
        #1;
        checks++;
        if ({state, ctl} !== {2'd2, CTL_LU}) begin
            failures++;
            $display("FAIL wait_release: got state=%0d ctl=%b want state=2 ctl=%b", state, ctl, CTL_LU);
        end
        step();
        idle_inputs();
        #1;
        checks++;
        if ({state, ld_haz} !== 3'b011) begin failures++; $display("FAIL wait_stall: got %b want 011", {state, ld_haz}); end
        step();
        checks++;
        if ({state, ld_haz, timeout} !== 4'b0000) begin failures++; $display("FAIL wait_done: got %b want 0000", {state, ld_haz, timeout}); end
    endtask

    task automatic test_stall_then_wait();
        load_use_inputs();
        step();
        idle_inputs();
        imem_wait = 1'b1;
        #1;
        checks++;
        if ({state, ld_haz, ctl} !== {2'd1, 1'b1, CTL_HOLD}) begin
            failures++;
            $display("FAIL stallwait_c1: got state=%0d ld_haz=%b ctl=%b want 1 1 %b", state, ld_haz, ctl, CTL_HOLD);
        end
        step();
        imem_wait = 1'b0;
        #1;
        checks++;
        if ({state, ld_haz, ctl} !== {2'd2, 1'b0, CTL_RUN}) begin
            failures++;
            $display("FAIL stallwait_c2: got state=%0d ld_haz=%b ctl=%b want 2 0 %b", state, ld_haz, ctl, CTL_RUN);
        end
        step();
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL stallwait_c3: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_stall();
        load_use_inputs();
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, ld_haz} !== 3'b000) begin failures++; $display("FAIL rststall_async: got %b want 000", {state, ld_haz}); end
        checks++;
        if (ctl !== CTL_HOLD) begin failures++; $display("FAIL rststall_ctl: got %b want %b", ctl, CTL_HOLD); end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if ({ld_stall_cnt, br_flush_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL rststall_cnt: got %0d/%0d want 0/0", ld_stall_cnt, br_flush_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({state, ld_haz, ctl} !== {3'b000, CTL_RUN}) begin
            failures++;
            $display("FAIL rststall_after: got state=%0d ld_haz=%b ctl=%b want 0 0 %b", state, ld_haz, ctl, CTL_RUN);
        end
    endtask

    task automatic test_timeout();
        idle_inputs();
        imem_wait = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (timeout !== (k >= 4)) begin
                failures++;
                $display("FAIL timeout_c%0d: got %b want %b", k, timeout, (k >= 4));
            end
        end
        imem_wait = 1'b0;
        step();
        step();
        checks++;
        if ({state, timeout} !== 3'b001) begin failures++; $display("FAIL timeout_sticky: got %b want 001", {state, timeout}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_reset: got %b want 0", timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_wait();
        test_stall_then_wait();
        test_reset_mid_stall();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
